// File: rtl/sprite_motion_ctrl.sv
// Per-frame position engine for one sprite: saturated velocity registers, bounded
// centre position with clamp / wrap / bounce edge handling, and edge-event reporting.
module sprite_motion_ctrl #(
    parameter int COORD_W   = 10,
    parameter int VEL_W     = 8,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 479,
    parameter int X_INIT    = 320,
    parameter int Y_INIT    = 240,
    parameter int SIZE      = 16,
    parameter int EDGE_MODE = 0,
    parameter int MAX_SPEED = 8
) (
    input  logic                     frame_clk,
    input  logic                     Reset,
    input  logic signed [VEL_W-1:0]  vel_x,
    input  logic signed [VEL_W-1:0]  vel_y,
    input  logic                     vel_valid,
    input  logic                     freeze,
    output logic [COORD_W-1:0]       pos_x,
    output logic [COORD_W-1:0]       pos_y,
    output logic [COORD_W-1:0]       size,
    output logic [3:0]               edge_hit,
    output logic [7:0]               hit_count,
    output logic                     moving
);

    localparam int MODE_WRAP   = 1;
    localparam int MODE_BOUNCE = 2;
    localparam int EW          = COORD_W + 2;

    typedef logic signed [EW-1:0] ext_t;

    localparam ext_t X_LO = ext_t'(X_MIN + SIZE);
    localparam ext_t X_HI = ext_t'(X_MAX - SIZE);
    localparam ext_t Y_LO = ext_t'(Y_MIN + SIZE);
    localparam ext_t Y_HI = ext_t'(Y_MAX - SIZE);

    localparam logic signed [VEL_W-1:0] V_MAX = VEL_W'(MAX_SPEED);
    localparam logic signed [VEL_W-1:0] V_MIN = VEL_W'(-MAX_SPEED);

    typedef enum logic [1:0] {IDLE, MOVING, HELD} state_t;

    typedef struct packed {
        logic [COORD_W-1:0] pos;
        logic               hit_lo;
        logic               hit_hi;
    } axis_t;

    function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [VEL_W-1:0] v);
        if (v > V_MAX)      return V_MAX;
        else if (v < V_MIN) return V_MIN;
        else                return v;
    endfunction

    // Extra headroom bits keep pos + vel from wrapping the unsigned coordinate.
    function automatic axis_t step_axis(input logic [COORD_W-1:0]      pos,
                                        input logic signed [VEL_W-1:0] vel,
                                        input ext_t                    lo,
                                        input ext_t                    hi);
        ext_t  nxt;
        axis_t r;
        nxt = ext_t'({2'b00, pos}) + {{(EW-VEL_W){vel[VEL_W-1]}}, vel};
        r.pos    = nxt[COORD_W-1:0];
        r.hit_lo = 1'b0;
        r.hit_hi = 1'b0;
        if (nxt < lo) begin
            r.hit_lo = 1'b1;
            r.pos    = (EDGE_MODE == MODE_WRAP) ? hi[COORD_W-1:0] : lo[COORD_W-1:0];
        end else if (nxt > hi) begin
            r.hit_hi = 1'b1;
            r.pos    = (EDGE_MODE == MODE_WRAP) ? lo[COORD_W-1:0] : hi[COORD_W-1:0];
        end
        return r;
    endfunction

    logic [COORD_W-1:0]      pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [VEL_W-1:0] vx_q, vx_d, vy_q, vy_d;
    logic [3:0]              edge_hit_q, edge_hit_d;
    logic [7:0]              hit_count_q, hit_count_d;
    state_t                  state_q, state_d;
    axis_t                   ax, ay;

    // NOTE: every output of this block is given a default first, so no path leaves a latch.
    always_comb begin
        ax          = step_axis(pos_x_q, vx_q, X_LO, X_HI);
        ay          = step_axis(pos_y_q, vy_q, Y_LO, Y_HI);
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        edge_hit_d  = 4'b0000;
        hit_count_d = hit_count_q;

        if (!freeze) begin
            pos_x_d    = ax.pos;
            pos_y_d    = ay.pos;
            edge_hit_d = {ay.hit_hi, ay.hit_lo, ax.hit_hi, ax.hit_lo};
            if (EDGE_MODE == MODE_BOUNCE) begin
                if (ax.hit_lo || ax.hit_hi) vx_d = -vx_q;
                if (ay.hit_lo || ay.hit_hi) vy_d = -vy_q;
            end
            if (edge_hit_d != 4'b0000 && hit_count_q != 8'hFF)
                hit_count_d = hit_count_q + 8'd1;
        end

        // A fresh command overrides any bounce negation on the same edge.
        if (vel_valid) begin
            vx_d = sat_vel(vel_x);
            vy_d = sat_vel(vel_y);
        end

        if (freeze)                            state_d = HELD;
        else if (vx_d != '0 || vy_d != '0)     state_d = MOVING;
        else                                   state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments; Reset is asynchronous.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            pos_x_q     <= COORD_W'(X_INIT);
            pos_y_q     <= COORD_W'(Y_INIT);
            vx_q        <= '0;
            vy_q        <= '0;
            edge_hit_q  <= 4'b0000;
            hit_count_q <= 8'd0;
            state_q     <= IDLE;
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            edge_hit_q  <= edge_hit_d;
            hit_count_q <= hit_count_d;
            state_q     <= state_d;
        end
    end

    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign size      = COORD_W'(SIZE);
    assign edge_hit  = edge_hit_q;
    assign hit_count = hit_count_q;
    assign moving    = (state_q == MOVING);

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Drives clamp, wrap and bounce instances with shared stimulus and compares each
// against an integer reference model of the sprite motion rules.
module tb_sprite_motion_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic [7:0] vel_x     = 8'd0;
    logic [7:0] vel_y     = 8'd0;
    logic       vel_valid = 1'b0;
    logic       freeze    = 1'b0;

    logic [9:0] pos_x_w     [3];
    logic [9:0] pos_y_w     [3];
    logic [9:0] size_w      [3];
    logic [3:0] edge_hit_w  [3];
    logic [7:0] hit_count_w [3];
    logic       moving_w    [3];

    always #5 frame_clk = ~frame_clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sprite_motion_ctrl #(.EDGE_MODE(g)) u_dut (
            .frame_clk (frame_clk),
            .Reset     (Reset),
            .vel_x     (vel_x),
            .vel_y     (vel_y),
            .vel_valid (vel_valid),
            .freeze    (freeze),
            .pos_x     (pos_x_w[g]),
            .pos_y     (pos_y_w[g]),
            .size      (size_w[g]),
            .edge_hit  (edge_hit_w[g]),
            .hit_count (hit_count_w[g]),
            .moving    (moving_w[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference state per edge mode (0 clamp, 1 wrap, 2 bounce).
    int px[3], py[3], vx[3], vy[3], eh[3], hc[3];
    bit mv[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 8)  return 8;
        if (v < -8) return -8;
        return v;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            px[m] = 320; py[m] = 240; vx[m] = 0; vy[m] = 0;
            eh[m] = 0;   hc[m] = 0;   mv[m] = 1'b0;
        end
    endtask

    task automatic move_axis(input int m, input int p, input int v, input int lo, input int hi,
                             output int np, output int nv, output int hit_lo, output int hit_hi);
        int n;
        n = p + v;
        np = n; nv = v; hit_lo = 0; hit_hi = 0;
        if (n < lo) begin
            hit_lo = 1;
            np = (m == 1) ? hi : lo;
            if (m == 2) nv = -v;
        end else if (n > hi) begin
            hit_hi = 1;
            np = (m == 1) ? lo : hi;
            if (m == 2) nv = -v;
        end
    endtask

    task automatic model_step(input bit valid, input logic [7:0] ax, input logic [7:0] ay,
                              input bit frz);
        int npx, npy, nvx, nvy, xl, xh, yl, yh;
        for (int m = 0; m < 3; m++) begin
            nvx = vx[m]; nvy = vy[m];
            eh[m] = 0;
            if (!frz) begin
                move_axis(m, px[m], vx[m], 16, 623, npx, nvx, xl, xh);
                move_axis(m, py[m], vy[m], 16, 463, npy, nvy, yl, yh);
                px[m] = npx; py[m] = npy;
                eh[m] = yh * 8 + yl * 4 + xh * 2 + xl;
                if (eh[m] != 0 && hc[m] < 255) hc[m]++;
            end
            if (valid) begin
                nvx = sat(int'($signed(ax)));
                nvy = sat(int'($signed(ay)));
            end
            vx[m] = nvx; vy[m] = nvy;
            mv[m] = !frz && (nvx != 0 || nvy != 0);
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 3; m++) begin
            check($sformatf("m%0d pos_x", m),     pos_x_w[m],     px[m]);
            check($sformatf("m%0d pos_y", m),     pos_y_w[m],     py[m]);
            check($sformatf("m%0d size", m),      size_w[m],      16);
            check($sformatf("m%0d edge_hit", m),  edge_hit_w[m],  eh[m]);
            check($sformatf("m%0d hit_count", m), hit_count_w[m], hc[m]);
            check($sformatf("m%0d moving", m),    moving_w[m],    mv[m]);
        end
    endtask

    task automatic step(input bit valid, input logic [7:0] ax, input logic [7:0] ay, input bit frz);
        vel_valid = valid; vel_x = ax; vel_y = ay; freeze = frz;
        @(posedge frame_clk);
        model_step(valid, ax, ay, frz);
        #1;
        compare_all();
    endtask

    task automatic do_reset_mid_cycle();
        #2 Reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("rst async pos_x", pos_x_w[0], 320);
        check("rst async moving", moving_w[0], 0);
        #2 Reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #22 Reset = 1'b0;
        #1;
        compare_all();
        check("rst pos_y", pos_y_w[1], 240);

        // One-frame velocity latency and saturation of out-of-range commands.
        step(1'b1, 8'd3, 8'd0, 1'b0);
        check("lat e0 pos_x", pos_x_w[0], 320);
        check("lat e0 moving", moving_w[0], 1);
        step(1'b0, 8'd0, 8'd0, 1'b0);
        check("lat e1 pos_x", pos_x_w[0], 323);
        step(1'b0, 8'd0, 8'd0, 1'b0);
        check("lat e2 pos_x", pos_x_w[0], 326);
        step(1'b1, 8'h64, 8'h80, 1'b0);
        step(1'b0, 8'd0, 8'd0, 1'b0);
        check("sat pos_x", pos_x_w[0], 337);
        check("sat pos_y", pos_y_w[0], 232);

        do_reset_mid_cycle();

        // Walk right to 620, then push past the right bound.
        step(1'b1, 8'd8, 8'd0, 1'b0);
        repeat (36) step(1'b0, 8'd0, 8'd0, 1'b0);
        step(1'b1, 8'd4, 8'd0, 1'b0);
        step(1'b1, 8'd5, 8'd0, 1'b0);
        check("clamp pre pos_x", pos_x_w[0], 620);
        step(1'b0, 8'd0, 8'd0, 1'b0);
        check("clamp hit pos_x", pos_x_w[0], 623);
        check("clamp hit edge", edge_hit_w[0], 4'b0010);
        check("wrap hit pos_x", pos_x_w[1], 16);
        step(1'b0, 8'd0, 8'd0, 1'b0);
        check("clamp again count", hit_count_w[0], 2);
        check("bounce back pos_x", pos_x_w[2], 618);
        step(1'b0, 8'd0, 8'd0, 1'b1);
        check("freeze edge", edge_hit_w[0], 0);
        check("freeze moving", moving_w[0], 0);

        // Randomised commands with occasional freezes.
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] rx, ry;
            if ($urandom_range(0, 1) == 0) begin
                rx = 8'($urandom_range(0, 16) - 8);
                ry = 8'($urandom_range(0, 16) - 8);
            end else begin
                rx = 8'($urandom);
                ry = 8'($urandom);
            end
            step($urandom_range(0, 2) == 0, rx, ry, $urandom_range(0, 7) == 0);
        end

        do_reset_mid_cycle();
        step(1'b1, 8'd8, 8'd8, 1'b0);
        repeat (300) step(1'b0, 8'd0, 8'd0, 1'b0);
        check("clamp sat count", hit_count_w[0], 255);
        check("clamp corner edge", edge_hit_w[0], 4'b1010);
        check("clamp corner pos_y", pos_y_w[0], 463);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
